// File: rtl/alu_pkg.sv
// Shared definitions for the registered integer ALU: op codes and sizing helpers.
package alu_pkg;

    localparam int DEFAULT_WIDTH = 32;

    // Width of a count that must hold every value from 0 to w inclusive.
    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

    // Decoder op codes; all 16 encodings are used.
    typedef enum logic [3:0] {
        OP_AND  = 4'b0000,
        OP_OR   = 4'b0001,
        OP_XOR  = 4'b0010,
        OP_NOR  = 4'b0011,
        OP_ADDU = 4'b0100,
        OP_SUBU = 4'b0101,
        OP_ADD  = 4'b0110,
        OP_SUB  = 4'b0111,
        OP_SLL  = 4'b1000,
        OP_SLLV = 4'b1001,
        OP_SRL  = 4'b1010,
        OP_SRLV = 4'b1011,
        OP_SLT  = 4'b1100,
        OP_SLTU = 4'b1101,
        OP_CLO  = 4'b1110,
        OP_CLZ  = 4'b1111
    } op_e;

endpackage

// File: rtl/alu_lzc.sv
// Leading-zero counter: number of zero bits above the highest set bit, WIDTH when value is 0.
module alu_lzc
    import alu_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = cnt_width(WIDTH)
) (
    input  logic [WIDTH-1:0] value,
    output logic [CNT_W-1:0] count
);

    // Priority encode from the LSB upwards so the highest set bit has the final say.
    always_comb begin
        // NOTE: count gets a value before the loop so no path leaves it unassigned (no latch).
        count = CNT_W'(WIDTH);
        for (int i = 0; i < WIDTH; i++) begin
            if (value[i]) begin
                count = CNT_W'(WIDTH - 1 - i);
            end
        end
    end

endmodule

// File: rtl/alu.sv
// Registered integer ALU for the execute stage: one combinational op mux feeding a single
// register stage that captures the result and its status flags.
module alu
    import alu_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       code,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic             in_valid,
    output logic [WIDTH-1:0] out,
    output logic             carry,
    output logic             overflow,
    output logic             zero,
    output logic             negative,
    output logic             out_valid
);

    localparam int CNT_W = cnt_width(WIDTH);
    localparam int SH_W  = $clog2(WIDTH);

    logic [SH_W-1:0]  sh;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;
    logic [WIDTH:0]   shl;
    logic [CNT_W-1:0] lead_zeros;
    logic [CNT_W-1:0] lead_ones;
    logic [WIDTH-1:0] res;
    logic             res_carry;
    logic             res_ovf;

    // Shared arithmetic: one extra bit on top holds carry (add) or borrow (subtract).
    assign sh   = in2[SH_W-1:0];
    assign sum  = {1'b0, in1} + {1'b0, in2};
    assign diff = {1'b0, in1} - {1'b0, in2};
    // The bit pushed into position WIDTH is the last one shifted out; zero when sh is 0.
    assign shl  = {1'b0, in1} << sh;

    // CLZ counts zeros of A directly; CLO counts zeros of the inverted operand.
    alu_lzc #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_clz (
        .value (in1),
        .count (lead_zeros)
    );

    alu_lzc #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_clo (
        .value (~in1),
        .count (lead_ones)
    );

    // Op mux: result, carry and overflow for the selected operation.
    always_comb begin
        res       = '0;
        res_carry = 1'b0;
        res_ovf   = 1'b0;
        unique case (op_e'(code))
            OP_AND:  res = in1 & in2;
            OP_OR:   res = in1 | in2;
            OP_XOR:  res = in1 ^ in2;
            OP_NOR:  res = ~(in1 | in2);
            OP_ADDU: {res_carry, res} = sum;
            OP_SUBU: {res_carry, res} = diff;
            OP_ADD: begin
                res     = sum[WIDTH-1:0];
                res_ovf = (in1[WIDTH-1] == in2[WIDTH-1]) && (res[WIDTH-1] != in1[WIDTH-1]);
            end
            OP_SUB: begin
                res     = diff[WIDTH-1:0];
                res_ovf = (in1[WIDTH-1] != in2[WIDTH-1]) && (res[WIDTH-1] != in1[WIDTH-1]);
            end
            OP_SLL:  {res_carry, res} = {in1, 1'b0};
            OP_SLLV: {res_carry, res} = shl;
            OP_SRL:  res = in1 >> 1;
            OP_SRLV: res = in1 >> sh;
            OP_SLT:  res = {{(WIDTH-1){1'b0}}, ($signed(in1) < $signed(in2))};
            OP_SLTU: res = {{(WIDTH-1){1'b0}}, (in1 < in2)};
            OP_CLO:  res = WIDTH'(lead_ones);
            OP_CLZ:  res = WIDTH'(lead_zeros);
            default: res = '0;
        endcase
    end

    // Output register: capture result and flags on valid cycles, hold them otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out       <= '0;
            carry     <= 1'b0;
            overflow  <= 1'b0;
            zero      <= 1'b0;
            negative  <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            out_valid <= in_valid;
            if (in_valid) begin
                out      <= res;
                carry    <= res_carry;
                overflow <= res_ovf;
                zero     <= (res == '0);
                negative <= res[WIDTH-1];
            end
        end
    end

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: a reference model fills a scoreboard queue as each op is
// issued, and the entry is popped and compared when the registered result appears.
module tb_alu;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  code;
    logic [31:0] in1;
    logic [31:0] in2;
    logic        in_valid;
    logic [31:0] out;
    logic        carry;
    logic        overflow;
    logic        zero;
    logic        negative;
    logic        out_valid;

    typedef struct {
        logic [31:0] out;
        logic        carry;
        logic        overflow;
        logic        zero;
        logic        negative;
    } exp_t;

    exp_t sb[$];
    exp_t last;
    int   checks = 0;
    int   errors = 0;

    alu #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .code      (code),
        .in1       (in1),
        .in2       (in2),
        .in_valid  (in_valid),
        .out       (out),
        .carry     (carry),
        .overflow  (overflow),
        .zero      (zero),
        .negative  (negative),
        .out_valid (out_valid)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // Reference model written independently of the RTL structure.
    function automatic exp_t model(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        int   s;
        int   n;
        e.out      = '0;
        e.carry    = 1'b0;
        e.overflow = 1'b0;
        s = int'(b[4:0]);
        n = 0;
        case (c)
            4'd0:  e.out = a & b;
            4'd1:  e.out = a | b;
            4'd2:  e.out = a ^ b;
            4'd3:  e.out = ~(a | b);
            4'd4: begin e.out = a + b; e.carry = (e.out < a); end
            4'd5: begin e.out = a - b; e.carry = (a < b); end
            4'd6: begin
                e.out = a + b;
                e.overflow = (a[31] == b[31]) && (e.out[31] != a[31]);
            end
            4'd7: begin
                e.out = a - b;
                e.overflow = (a[31] != b[31]) && (e.out[31] != a[31]);
            end
            4'd8: begin e.out = a << 1; e.carry = a[31]; end
            4'd9: begin
                e.out = a << s;
                e.carry = (s == 0) ? 1'b0 : a[32 - s];
            end
            4'd10: e.out = a >> 1;
            4'd11: e.out = a >> s;
            4'd12: e.out = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd13: e.out = (a < b) ? 32'd1 : 32'd0;
            4'd14: begin
                for (int i = 31; i >= 0 && a[i]; i--) n++;
                e.out = 32'(n);
            end
            default: begin
                for (int i = 31; i >= 0 && !a[i]; i--) n++;
                e.out = 32'(n);
            end
        endcase
        e.zero     = (e.out == 32'd0);
        e.negative = e.out[31];
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic chk_regs(input string tag, input exp_t e);
        chk({tag, ".out"}, out, e.out);
        chk({tag, ".carry"}, 32'(carry), 32'(e.carry));
        chk({tag, ".overflow"}, 32'(overflow), 32'(e.overflow));
        chk({tag, ".zero"}, 32'(zero), 32'(e.zero));
        chk({tag, ".negative"}, 32'(negative), 32'(e.negative));
    endtask

    // Drive one op between edges and record what it should produce.
    task automatic issue(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        code     = c;
        in1      = a;
        in2      = b;
        in_valid = 1'b1;
        sb.push_back(model(c, a, b));
    endtask

    // Wait for the registering edge and compare against the oldest scoreboard entry.
    task automatic collect(input string tag);
        exp_t e;
        @(posedge clk);
        #1;
        chk({tag, ".out_valid"}, 32'(out_valid), 32'd1);
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s scoreboard empty observed=%h expected=entry", tag, out);
        end else begin
            e = sb.pop_front();
            last = e;
            chk_regs(tag, e);
        end
    endtask

    task automatic run_op(input string tag, input logic [3:0] c, input logic [31:0] a,
                          input logic [31:0] b);
        issue(c, a, b);
        collect(tag);
    endtask

    // Idle cycle: outputs must hold the last result while out_valid drops.
    task automatic idle(input string tag);
        @(negedge clk);
        in_valid = 1'b0;
        in1      = $urandom;
        in2      = $urandom;
        code     = 4'($urandom_range(0, 15));
        @(posedge clk);
        #1;
        chk({tag, ".out_valid"}, 32'(out_valid), 32'd0);
        chk_regs(tag, last);
    endtask

    initial begin
        exp_t zeros;
        zeros = '{out: 32'd0, carry: 1'b0, overflow: 1'b0, zero: 1'b0, negative: 1'b0};
        rst      = 1'b1;
        in_valid = 1'b0;
        code     = 4'd0;
        in1      = '0;
        in2      = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset.out_valid", 32'(out_valid), 32'd0);
        chk_regs("reset", zeros);
        @(negedge clk);
        rst = 1'b0;

        // Directed cases from the op map and its boundaries.
        run_op("and",       4'b0000, 32'hFFFF_FFFF, 32'hFFFF_FFF0);
        run_op("or",        4'b0001, 32'h0F0F_0000, 32'h0000_00F0);
        run_op("xor",       4'b0010, 32'hAAAA_5555, 32'hFFFF_0000);
        run_op("nor",       4'b0011, 32'h0000_0000, 32'h0000_0000);
        run_op("addu_wrap", 4'b0100, 32'hFFFF_FFFF, 32'h0000_0001);
        run_op("subu_eq",   4'b0101, 32'h1234_5678, 32'h1234_5678);
        run_op("subu_brw",  4'b0101, 32'h0000_0001, 32'h0000_0002);
        run_op("add_ovf",   4'b0110, 32'h7FFF_FFFF, 32'h0000_0001);
        run_op("sub_ovf",   4'b0111, 32'h8000_0000, 32'h0000_0001);
        run_op("sll",       4'b1000, 32'h8000_0001, 32'h0000_0000);
        run_op("sllv_0",    4'b1001, 32'hDEAD_BEEF, 32'hFFFF_FFE0);
        run_op("sllv_4",    4'b1001, 32'h1800_0001, 32'h0000_0004);
        run_op("sllv_31",   4'b1001, 32'h0000_0003, 32'h0000_001F);
        run_op("srl",       4'b1010, 32'h8000_0003, 32'h0000_0000);
        run_op("srlv_0",    4'b1011, 32'h8765_4321, 32'h0000_0000);
        run_op("srlv_8",    4'b1011, 32'h8765_4321, 32'h0000_0008);
        run_op("slt",       4'b1100, 32'hFFFF_FFFF, 32'h0000_0001);
        run_op("sltu",      4'b1101, 32'hFFFF_FFFF, 32'h0000_0001);
        run_op("clz_16",    4'b1111, 32'h0000_FFFF, 32'h0000_0000);
        run_op("clo_4",     4'b1110, 32'hF000_0000, 32'h0000_0000);
        run_op("clz_32",    4'b1111, 32'h0000_0000, 32'h0000_0000);
        run_op("clo_32",    4'b1110, 32'hFFFF_FFFF, 32'h0000_0000);
        idle("hold");
        idle("hold2");

        // Back-to-back ops with no idle gap.
        issue(4'b0100, 32'h0000_0010, 32'h0000_0020);
        collect("b2b_0");
        issue(4'b0110, 32'h8000_0000, 32'h8000_0000);
        collect("b2b_1");

        // Random ops, with some operands forced to edge values.
        for (int i = 0; i < 40; i++) begin
            logic [31:0] a;
            logic [31:0] b;
            a = $urandom;
            b = $urandom;
            if (i % 5 == 0) a = 32'h8000_0000;
            if (i % 7 == 0) b = 32'hFFFF_FFFF;
            if (i % 3 == 0) a = a >> (i % 32);
            run_op("rand", 4'($urandom_range(0, 15)), a, b);
        end
        idle("hold_rand");

        // Reset in the middle of a valid op: outputs clear at once and the op is dropped.
        run_op("pre_rst", 4'b0010, 32'hFFFF_FFFF, 32'h0000_0000);
        @(negedge clk);
        code     = 4'b0100;
        in1      = 32'hFFFF_FFFF;
        in2      = 32'h0000_0001;
        in_valid = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        chk("rst_async.out_valid", 32'(out_valid), 32'd0);
        chk_regs("rst_async", zeros);
        @(posedge clk);
        #1;
        chk("rst_held.out_valid", 32'(out_valid), 32'd0);
        chk_regs("rst_held", zeros);
        @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b0;
        last     = zeros;
        @(posedge clk);
        #1;
        chk("post_rst.out_valid", 32'(out_valid), 32'd0);
        chk_regs("post_rst", last);
        run_op("after_rst", 4'b0101, 32'h0000_0005, 32'h0000_0003);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
